// File: rtl/mul8b_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Holds the FSM encoding, widths and the per-step shift table.
package mul8b_seq_pkg;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    sh = 4'd0;
    unique case (step)
      2'd0: sh = 4'd0;
      2'd1: sh = 4'd4;
      2'd2: sh = 4'd4;
      2'd3: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul8b_seq_mul4b.sv
// Shared 4x4 unsigned multiplier datapath.
// Purely combinational; one partial product per cycle.
module mul4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mul8b_seq.sv
// Sequential 8x8 unsigned multiplier built from one 4x4 multiplier.
// Four MUL cycles accumulate shifted partial products.
module mul8b_seq
  import mul8b_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   ina,
  input  logic [OPW-1:0]   inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out,
  output logic             busy
);

  state_t             state;
  state_t             state_nx;
  logic [1:0]         step;
  logic [PRODW-1:0]   acc;
  logic [OPW-1:0]     opa;
  logic [OPW-1:0]     opb;
  logic [3:0]         ma;
  logic [3:0]         mb;
  logic [7:0]         pp;
  logic [PRODW-1:0]   addend;

  mul4b u_mul4b (
    .a (ma),
    .b (mb),
    .p (pp)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and nibble selection for the shared multiplier
  always_comb begin
    state_nx = state;
    ma       = 4'd0;
    mb       = 4'd0;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nx = MUL;
      end
      MUL: begin
        ma = step[0] ? opa[7:4] : opa[3:0];
        mb = step[1] ? opb[7:4] : opb[3:0];
        if (step == 2'd3) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign addend = PRODW'(pp) << step_shift(step);

  // Operand capture, step counter and accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= 2'd0;
      acc  <= '0;
      opa  <= '0;
      opb  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa  <= ina;
            opb  <= inb;
            acc  <= '0;
            step <= 2'd0;
          end
        end
        MUL: begin
          acc  <= acc + addend;
          step <= step + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_mul8b_seq.sv
// Directed bench for mul8b_seq.
// Checks latency, stalls, back-to-back, reset abort, and a product sweep.
module tb_mul8b_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ina;
  logic [7:0]  inb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul8b_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ina       (ina),
    .inb       (inb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0]  a,
                     input logic [7:0]  b,
                     input int          stall,
                     input bit          poke,
                     input logic [15:0] exp);
    int n;
    check("rdy", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    ina       = a;
    inb       = b;
    out_ready = 1'b0;
    @(negedge clk);
    n        = 0;
    in_valid = 1'b0;
    ina      = ~a;
    inb      = ~b;
    if (poke) begin
      in_valid = 1'b1;
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      ina      = a ^ 8'h5a;
    end
    while (!out_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("lat", 32'(n), 32'd4);
    for (int i = 0; i < stall; i++) begin
      check("hold_v", 32'(out_valid), 32'd1);
      check("hold", 32'(out), 32'(exp));
      @(negedge clk);
    end
    check("prod", 32'(out), 32'(exp));
    check("bsy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle", 32'(in_ready), 32'd1);
    check("out0", 32'(out), 32'd0);
  endtask

  initial begin
    int acc_cyc[2];
    logic [15:0] res[2];
    int nacc;
    int got;
    logic [7:0] a;
    logic [7:0] b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    ina       = 8'h00;
    inb       = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_bsy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'd0);

    run(8'hFF, 8'hFF, 0, 1'b0, 16'hFE01);
    run(8'h12, 8'h34, 3, 1'b0, 16'h03A8);

    // back-to-back with in_valid held high
    nacc      = 0;
    got       = 0;
    in_valid  = 1'b1;
    ina       = 8'h00;
    inb       = 8'hAB;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 2; c++) begin
      if (in_ready && in_valid && nacc < 2) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      if (out_valid) begin
        res[got] = out;
        got++;
      end
      @(negedge clk);
      if (nacc == 1) begin
        ina = 8'hAB;
        inb = 8'h01;
      end
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_n", 32'(got), 32'd2);
    check("b2b_p0", 32'(res[0]), 32'h0000);
    check("b2b_p1", 32'(res[1]), 32'h00AB);
    check("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    @(negedge clk);

    // operand changes and in_valid pulse while busy
    run(8'h5A, 8'hC3, 0, 1'b1, 16'h448E);
    @(negedge clk);
    check("nox_ir", 32'(in_ready), 32'd1);
    check("nox_bsy", 32'(busy), 32'd0);

    // reset during step 2
    in_valid = 1'b1;
    ina      = 8'h80;
    inb      = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ra_ov", 32'(out_valid), 32'd0);
    check("ra_ir", 32'(in_ready), 32'd1);
    check("ra_out", 32'(out), 32'd0);
    check("ra_bsy", 32'(busy), 32'd0);
    run(8'h03, 8'h05, 0, 1'b0, 16'h000F);

    // coarse sweep with random stalls
    for (int i = 0; i < 256; i += 15) begin
      for (int j = 0; j < 256; j += 15) begin
        a = 8'(i);
        b = 8'(j);
        run(a, b, int'($urandom_range(0, 2)), 1'b0, 16'(a) * 16'(b));
      end
    end
    run(8'hFF, 8'h01, 1, 1'b0, 16'h00FF);
    run(8'h01, 8'hFF, 0, 1'b0, 16'h00FF);
    run(8'h0F, 8'hF0, 2, 1'b0, 16'h0E10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
